output_result_drain: RTL and testbench

- Drains accumulated transpose-convolution results from the Dimension output-result BRAM banks after the output microsequencer pulses done.
- Reads one row (one address across all banks) per BRAM access and serializes it bank-by-bank onto a valid/ready stream toward the writeback/DMA path.
- Owns BRAM port B of every bank while busy. The upstream controller keeps the accumulation path idle during a drain.

---
 rtl/output_result_drain.sv | 226 ++++++++++++++++++++++
 tb/tb_output_result_drain.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_result_drain.sv
// output_result_drain: after accumulation finishes, reads the output-result
// BRAM banks one row at a time over port B and serializes each row bank by
// bank onto a valid/ready stream toward writeback/DMA.
// Optional build macro OUTPUT_DRAIN_PREFETCH_EN: a ping-pong row buffer lets the
// read of row r+1 overlap the streaming of row r, for Dimension cycles per row.
module output_result_drain #(
    parameter int DW        = 16,
    parameter int Dimension = 16,
    parameter int ADDR_W    = 9,
    parameter int RD_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W:0]         num_rows,
    output logic [Dimension-1:0]    enb_drain,
    output logic [ADDR_W-1:0]       addrb_drain,
    input  logic [Dimension*DW-1:0] doutb_flat,
    output logic [DW-1:0]           m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    busy,
    output logic                    done
);

    localparam int BW = (Dimension > 1) ? $clog2(Dimension) : 1;
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W:0] ROW_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_CAPTURE, S_SEND, S_NEXT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   num_rows_q;
    logic [ADDR_W:0]   row_cnt;
    logic [ADDR_W:0]   row_inc;
    logic [BW-1:0]     bank_cnt;
    logic [CW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic              last_bank;
    logic              send_valid;
    logic              beat;

`ifdef OUTPUT_DRAIN_PREFETCH_EN
    localparam int NBUF = 2;
    logic          buf_sel;    // buffer currently being streamed
    logic          pf_active;  // prefetch read in flight
    logic          pf_full;    // idle buffer holds the next row
    logic [CW-1:0] pf_cnt;
    logic          more_rows;
    assign more_rows = row_inc < num_rows_q;
`else
    localparam int NBUF = 1;
`endif

    logic [DW-1:0] row_buf [NBUF][Dimension];

    assign row_inc   = row_cnt + ROW_ONE;
    assign last_bank = (bank_cnt == BW'(Dimension - 1));

`ifdef OUTPUT_DRAIN_PREFETCH_EN
    // Hold back the final beat of a row until the next row is in the idle buffer.
    assign send_valid = (state_q == S_SEND) && !(last_bank && more_rows && !pf_full);
`else
    assign send_valid = (state_q == S_SEND);
`endif
    assign beat = send_valid && m_tready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update from the same pre-edge values, exactly as flops do.
            state_q <= state_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d     = state_q;
        enb_drain   = '0;
        addrb_drain = addr_hold;
        m_tvalid    = send_valid;
        m_tdata     = '0;
        m_tlast     = 1'b0;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (num_rows == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                enb_drain   = '1;
                addrb_drain = row_cnt[ADDR_W-1:0];
                state_d     = (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                enb_drain   = '1;
                addrb_drain = row_cnt[ADDR_W-1:0];
                if (wait_cnt == CW'(RD_LAT - 2)) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                enb_drain   = '1;
                addrb_drain = row_cnt[ADDR_W-1:0];
                state_d     = S_SEND;
            end
            S_SEND: begin
`ifdef OUTPUT_DRAIN_PREFETCH_EN
                m_tdata = row_buf[buf_sel][bank_cnt];
`else
                m_tdata = row_buf[0][bank_cnt];
`endif
                m_tlast = last_bank && (row_inc == num_rows_q);
                if (beat && last_bank) begin
`ifdef OUTPUT_DRAIN_PREFETCH_EN
                    state_d = pf_full ? S_SEND : S_NEXT;
`else
                    state_d = S_NEXT;
`endif
                end
            end
            S_NEXT: begin
                state_d = (row_inc == num_rows_q) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef OUTPUT_DRAIN_PREFETCH_EN
        if (pf_active) begin
            enb_drain   = '1;
            addrb_drain = row_inc[ADDR_W-1:0];
        end
`endif
    end

    // Datapath: counters, row buffer capture and (optionally) the prefetch engine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_rows_q <= '0;
            row_cnt    <= '0;
            bank_cnt   <= '0;
            wait_cnt   <= '0;
            addr_hold  <= '0;
            // NOTE: the row buffer is only a few registers, not a RAM, so it is
            // cleared in reset like any other state; a real memory would not be.
            for (int b = 0; b < NBUF; b++)
                for (int k = 0; k < Dimension; k++)
                    row_buf[b][k] <= '0;
`ifdef OUTPUT_DRAIN_PREFETCH_EN
            buf_sel   <= 1'b0;
            pf_active <= 1'b0;
            pf_full   <= 1'b0;
            pf_cnt    <= '0;
`endif
        end else begin
            addr_hold <= addrb_drain;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_rows_q <= num_rows;
                        row_cnt    <= '0;
                    end
                end
                S_READ: wait_cnt <= '0;
                S_WAIT: wait_cnt <= wait_cnt + CW'(1);
                S_CAPTURE: begin
                    for (int k = 0; k < Dimension; k++)
`ifdef OUTPUT_DRAIN_PREFETCH_EN
                        row_buf[buf_sel][k] <= doutb_flat[k*DW +: DW];
`else
                        row_buf[0][k] <= doutb_flat[k*DW +: DW];
`endif
                    bank_cnt <= '0;
                end
                S_SEND: begin
                    if (beat) begin
                        if (last_bank) begin
                            bank_cnt <= '0;
`ifdef OUTPUT_DRAIN_PREFETCH_EN
                            if (pf_full) begin
                                buf_sel <= ~buf_sel;
                                pf_full <= 1'b0;
                                row_cnt <= row_inc;
                            end
`endif
                        end else begin
                            bank_cnt <= bank_cnt + BW'(1);
                        end
                    end
                end
                S_NEXT: row_cnt <= row_inc;
                default: ;
            endcase
`ifdef OUTPUT_DRAIN_PREFETCH_EN
            if (state_q == S_IDLE) begin
                buf_sel   <= 1'b0;
                pf_active <= 1'b0;
                pf_full   <= 1'b0;
            end else if (pf_active) begin
                // Same timing as READ/WAIT/CAPTURE: capture after RD_LAT enabled edges.
                if (pf_cnt == CW'(RD_LAT)) begin
                    for (int k = 0; k < Dimension; k++)
                        row_buf[~buf_sel][k] <= doutb_flat[k*DW +: DW];
                    pf_active <= 1'b0;
                    pf_full   <= 1'b1;
                end else begin
                    pf_cnt <= pf_cnt + CW'(1);
                end
            end else if (state_q == S_SEND && !pf_full && more_rows) begin
                pf_active <= 1'b1;
                pf_cnt    <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_output_result_drain.sv
// Testbench for output_result_drain: behavioural BRAM model, queue scoreboard
// fed by the stimulus, and an independent monitor comparing every presented beat.
module tb_output_result_drain;

    localparam int DW = 16, D = 16, ADDR_W = 9, RD_LAT = 2;
`ifdef OUTPUT_DRAIN_PREFETCH_EN
    localparam int EXP_CYC3 = 1 + (RD_LAT + 1) + 3 * D + 2;
`else
    localparam int EXP_CYC3 = 3 * (D + RD_LAT + 2) + 2;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W:0]     num_rows = '0;
    logic [D-1:0]        enb_drain;
    logic [ADDR_W-1:0]   addrb_drain;
    logic [D*DW-1:0]     doutb_flat;
    logic [DW-1:0]       m_tdata;
    logic                m_tvalid, m_tready, m_tlast, busy, done;

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    beat_t exp_q[$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, hs_cnt = 0, done_cnt = 0, done_cyc = 0, enb_cnt = 0, valid_cnt = 0;
    int start_cyc = 0;
    logic prev_stall = 1'b0;
    logic toggle_mode = 1'b0;
    logic ready_r = 1'b1;
    logic [3:0] pat = 4'b1001;
    int pidx = 0;

    output_result_drain #(.DW(DW), .Dimension(D), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .enb_drain(enb_drain), .addrb_drain(addrb_drain), .doutb_flat(doutb_flat),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: bank k, address a holds (a<<8 | k); RD_LAT-deep enabled pipeline.
    function automatic logic [DW-1:0] bram_word(input int a, input int k);
        return DW'((a << 8) | k);
    endfunction

    logic [D*DW-1:0] pipe [RD_LAT];
    always @(posedge clk) begin
        for (int k = 0; k < D; k++) begin
            if (enb_drain[k]) begin
                pipe[0][k*DW +: DW] <= bram_word(int'(addrb_drain), k);
                for (int s = 1; s < RD_LAT; s++)
                    pipe[s][k*DW +: DW] <= pipe[s-1][k*DW +: DW];
            end
        end
    end
    assign doutb_flat = pipe[RD_LAT-1];

    // Ready driver: constant 1, or the repeating 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        if (toggle_mode) begin
            ready_r = pat[pidx];
            pidx = (pidx + 1) % 4;
        end else begin
            ready_r = 1'b1;
        end
    end
    assign m_tready = ready_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({m_tvalid, m_tlast, done, busy, enb_drain, addrb_drain, m_tdata});
    endfunction

    // Monitor: compares every presented beat against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) check("valid_held_in_stall", 64'(m_tvalid), 64'd1);
            if (m_tvalid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_tdata);
                end else begin
                    check("tdata", 64'(m_tdata), 64'(exp_q[0].data));
                    check("tlast", 64'(m_tlast), 64'(exp_q[0].last));
                    if (m_tready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 64'(busy), 64'd1);
            end
            if (enb_drain != '0) begin
                enb_cnt++;
                check("enb_only_when_busy", 64'(busy), 64'd1);
            end
            prev_stall = m_tvalid && !m_tready;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_rows(input int n);
        for (int r = 0; r < n; r++)
            for (int k = 0; k < D; k++)
                exp_q.push_back('{data: bram_word(r, k), last: (r == n - 1) && (k == D - 1)});
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        num_rows = (ADDR_W+1)'(n);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int t = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    initial begin
        int d0, h0, e0, v0, t, vcyc;

        // Reset and idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("outputs_in_reset", all_outs(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            repeat (3) @(negedge clk);
            check("idle_outputs", all_outs(), 64'd0);
        end

        // Three rows, constant ready: order, tlast, total cycles, latency.
        push_rows(3);
        d0 = done_cnt;
        pulse_start(3);
        t = 0;
        while (!m_tvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        vcyc = cyc;
        check("first_valid_latency", 64'(vcyc - start_cyc), 64'(RD_LAT + 2));
        wait_done(300, "rows3");
        check("rows3_total_cycles", 64'(done_cyc - start_cyc + 1), 64'(EXP_CYC3));
        repeat (5) @(posedge clk);
        check("rows3_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rows3_single_done", 64'(done_cnt - d0), 64'd1);

        // Zero rows: done one cycle after accept, no stream, no BRAM access.
        e0 = enb_cnt;
        v0 = valid_cnt;
        pulse_start(0);
        wait_done(10, "rows0");
        check("rows0_done_latency", 64'(done_cyc - start_cyc), 64'd1);
        check("rows0_no_enb", 64'(enb_cnt - e0), 64'd0);
        check("rows0_no_valid", 64'(valid_cnt - v0), 64'd0);

        // Two rows with ready toggling 1,0,0,1.
        push_rows(2);
        h0 = hs_cnt;
        toggle_mode = 1'b1;
        pulse_start(2);
        wait_done(600, "toggle");
        toggle_mode = 1'b0;
        repeat (3) @(posedge clk);
        check("toggle_queue_empty", 64'(exp_q.size()), 64'd0);
        check("toggle_beats", 64'(hs_cnt - h0), 64'd32);

        // Start re-pulsed mid-drain is ignored.
        push_rows(2);
        d0 = done_cnt;
        h0 = hs_cnt;
        pulse_start(2);
        repeat (10) @(posedge clk);
        pulse_start(5);
        wait_done(300, "restart");
        repeat (30) @(posedge clk);
        check("restart_single_done", 64'(done_cnt - d0), 64'd1);
        check("restart_beats", 64'(hs_cnt - h0), 64'd32);
        check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset during row 1 beat 5, then a clean one-row drain.
        push_rows(2);
        h0 = hs_cnt;
        pulse_start(2);
        t = 0;
        while (hs_cnt - h0 < D + 5 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("reach_row1_beat5", 64'(hs_cnt - h0), 64'(D + 5));
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        check("outputs_after_midreset", all_outs(), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
        push_rows(1);
        pulse_start(1);
        wait_done(200, "after_reset");
        repeat (3) @(posedge clk);
        check("after_reset_queue_empty", 64'(exp_q.size()), 64'd0);
        check("after_reset_single_done", 64'(done_cnt - d0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
